// File: rtl/mdu_hilo_pkg.sv
// Purpose: shared encodings for the multiply/divide unit and its HI/LO pair.
// Latency: n/a (constants only).
// Backpressure: n/a; the stall controller uses Busy from mdu_hilo.
package mdu_hilo_pkg;

  // MDUOp encodings as driven by the decoder
  localparam logic [2:0] MDU_NOP   = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;
  localparam logic [2:0] MDU_RSVD  = 3'd7;

  // Default Busy durations (legal range 1..15, fits the 4-bit counter)
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // FSM state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/mdu_hilo.sv
// Purpose: multi-cycle mult/div unit owning HI/LO; also services mthi/mtlo.
// Latency: mult ops MULT_CYCLES, div ops DIV_CYCLES of Busy; mthi/mtlo next edge.
// Backpressure: none; Start while Busy is ignored, the stall controller holds the pipe.
// Ports: clk, reset (async active-low), Start/MDUOp/SrcA/SrcB request,
//        Busy (high while an op is in flight), HI/LO register outputs.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Full 64-bit products; sign-extending to 64 bits makes the low 64 bits exact.
  logic [63:0] prod_s, prod_u;
  assign prod_u = {32'b0, SrcA} * {32'b0, SrcB};
  assign prod_s = $signed({{32{SrcA[31]}}, SrcA}) * $signed({{32{SrcB[31]}}, SrcB});

  // Signed division done on magnitudes so 0x80000000 / -1 wraps cleanly to
  // quotient 0x80000000, remainder 0. Divisor forced to 1 when zero only to
  // keep the divider well defined; that result is never written back.
  logic        div_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;
  assign div_sgn = (MDUOp == MDU_DIV);
  assign a_neg   = div_sgn & SrcA[31];
  assign b_neg   = div_sgn & SrcB[31];
  assign a_mag   = a_neg ? (~SrcA + 32'd1) : SrcA;
  assign b_mag   = b_neg ? (~SrcB + 32'd1) : SrcB;
  assign b_div   = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / b_div;
  assign r_mag   = a_mag % b_div;
  assign quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem     = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (state_q == ST_IDLE) begin
      if (Start) begin
        case (MDUOp)
          MDU_MULT, MDU_MULTU: begin
            {pend_hi_d, pend_lo_d} = (MDUOp == MDU_MULT) ? prod_s : prod_u;
            pend_wr_d = 1'b1;
            cnt_d     = 4'(MULT_CYCLES - 1);
            state_d   = ST_RUN;
          end
          MDU_DIV, MDU_DIVU: begin
            pend_hi_d = rem;
            pend_lo_d = quot;
            // Divide by zero still burns the full latency but leaves HI/LO alone
            pend_wr_d = (SrcB != 32'd0);
            cnt_d     = 4'(DIV_CYCLES - 1);
            state_d   = ST_RUN;
          end
          MDU_MTHI: hi_d = SrcA;
          MDU_MTLO: lo_d = SrcA;
          default: ;
        endcase
      end
    end else begin
      // Requests arriving while running are dropped here by construction
      if (cnt_q == 4'd0) begin
        state_d = ST_IDLE;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy = (state_q == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
